// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: icache line-request port, decode instruction stream and redirect input.
interface fetch_unit_if #(
    parameter int LINE_W = 512
);
    logic [31:0]       req_pc;
    logic              req_rd;
    logic              req_accept;
    logic [LINE_W-1:0] req_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr_data;
    logic [31:0]       instr_pc;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;

    modport master (
        output req_pc, req_rd,
        input  req_accept, req_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  req_pc, req_rd,
        output req_accept, req_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests icache lines, streams 32-bit words with PCs to decode.
// Optional next-line prefetch buffer enabled by defining FETCH_NEXT_LINE_PREFETCH_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          LINE_W   = 512,
    parameter int          OFF_W    = 6
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int               WPL      = LINE_W / 32;
    localparam int               IDX_W    = OFF_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WPL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [31:0]       r_fetch_pc, w_fetch_pc_nxt;
    logic [31:0]       r_drain_pc, w_drain_pc_nxt;
    logic [LINE_W-1:0] r_line, w_line_nxt;
    logic              w_line_load;

    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_cur_line;
    logic [31:0]       w_redirect_pc;
    logic              w_fire;

    assign w_idx         = r_fetch_pc[OFF_W-1:2];
    assign w_cur_line    = {r_fetch_pc[31:OFF_W], {OFF_W{1'b0}}};
    assign w_redirect_pc = bus.redirect_pc & ~32'h3;
    assign w_fire        = bus.instr_valid && bus.instr_ready;

`ifdef FETCH_NEXT_LINE_PREFETCH_EN
    localparam logic [31:0] LINE_BYTES = 32'(LINE_W / 8);

    logic [LINE_W-1:0] r_pf_line;
    logic              r_pf_valid, w_pf_valid_nxt;
    logic              w_pf_load;
    logic              w_line_from_pf;
    logic              w_accept;

    assign w_accept   = bus.req_rd && bus.req_accept;
    assign w_line_nxt = w_line_from_pf ? r_pf_line : bus.req_data;
`else
    assign w_line_nxt = bus.req_data;
`endif

    // DRAIN keeps presenting the abandoned request until icache takes it.
    always_comb begin
        bus.req_rd = 1'b0;
        bus.req_pc = w_cur_line;
        unique case (r_state)
            ST_REQ: bus.req_rd = 1'b1;
            ST_DRAIN: begin
                bus.req_rd = 1'b1;
                bus.req_pc = r_drain_pc;
            end
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
            ST_STREAM: begin
                bus.req_rd = !r_pf_valid;
                bus.req_pc = w_cur_line + LINE_BYTES;
            end
`endif
            default: ;
        endcase
    end

    assign bus.instr_valid = (r_state == ST_STREAM);
    assign bus.instr_data  = bus.instr_valid ? r_line[{w_idx, 5'd0} +: 32] : 32'h0;
    assign bus.instr_pc    = r_fetch_pc;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drain_pc_nxt = r_drain_pc;
        w_line_load    = 1'b0;
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
        w_pf_valid_nxt = r_pf_valid;
        w_pf_load      = 1'b0;
        w_line_from_pf = 1'b0;
`endif
        if (bus.redirect_valid) begin
            w_fetch_pc_nxt = w_redirect_pc;
            w_drain_pc_nxt = bus.req_pc;
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
            w_pf_valid_nxt = 1'b0;
`endif
            w_state_nxt = (bus.req_rd && !bus.req_accept) ? ST_DRAIN : ST_REQ;
        end else begin
            unique case (r_state)
                ST_IDLE: w_state_nxt = ST_REQ;
                ST_REQ: begin
                    if (bus.req_accept) begin
                        w_line_load = 1'b1;
                        w_state_nxt = ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (bus.req_accept) w_state_nxt = ST_REQ;
                end
                ST_STREAM: begin
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
                    if (w_accept) begin
                        w_pf_load      = 1'b1;
                        w_pf_valid_nxt = 1'b1;
                    end
`endif
                    if (w_fire) begin
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                        if (w_idx == LAST_IDX) begin
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
                            if (r_pf_valid) begin
                                w_line_load    = 1'b1;
                                w_line_from_pf = 1'b1;
                                w_pf_valid_nxt = 1'b0;
                            end else if (w_accept) begin
                                w_line_load    = 1'b1;
                                w_pf_load      = 1'b0;
                                w_pf_valid_nxt = 1'b0;
                            end else begin
                                w_state_nxt = ST_REQ;
                            end
`else
                            w_state_nxt = ST_REQ;
`endif
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_drain_pc <= {RESET_PC[31:OFF_W], {OFF_W{1'b0}}};
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
            r_pf_valid <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drain_pc <= w_drain_pc_nxt;
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
            r_pf_valid <= w_pf_valid_nxt;
`endif
        end
    end

    // NOTE: line buffers are pure data storage; validity lives in r_state/r_pf_valid, so they take no reset.
    always_ff @(posedge clk) begin
        if (w_line_load) r_line <= w_line_nxt;
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
        if (w_pf_load) r_pf_line <= bus.req_data;
`endif
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit; icache is a combinational memory model.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam int          LINE_W   = 512;

    logic clk = 1'b0;
    logic rst;

    fetch_unit_if #(.LINE_W(LINE_W)) bus ();

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .LINE_W  (LINE_W),
        .OFF_W   (6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Word at byte address 0x100 is 0xA000_0000, incrementing by one per word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return 32'hA000_0000 + ((addr >> 2) - 32'h40);
    endfunction

    always_comb begin
        bus.req_data = '0;
        for (int i = 0; i < LINE_W / 32; i++)
            bus.req_data[i*32 +: 32] = mem_word(bus.req_pc + 32'(i * 4));
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        acc;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic        chk_req;
        logic        erd;
        logic [31:0] ereq;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rdy, input logic acc, input logic rv,
                                input logic [31:0] rpc, input logic ev, input logic [31:0] epc,
                                input logic chk_req, input logic erd, input logic [31:0] ereq);
        vec_t v;
        v.rdy = rdy; v.acc = acc; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.chk_req = chk_req; v.erd = erd; v.ereq = ereq;
        return v;
    endfunction

    // Drive at negedge, sample 1 ns later, then advance one full cycle.
    task automatic step(input vec_t v, input string tag);
        bus.instr_ready    = v.rdy;
        bus.req_accept     = v.acc;
        bus.redirect_valid = v.rv;
        bus.redirect_pc    = v.rpc;
        #1;
        check({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(v.ev));
        if (v.ev) begin
            check({tag, ".instr_pc"}, bus.instr_pc, v.epc);
            check({tag, ".instr_data"}, bus.instr_data, mem_word(v.epc));
        end
        if (v.chk_req) begin
            check({tag, ".req_rd"}, 32'(bus.req_rd), 32'(v.erd));
            if (v.erd) check({tag, ".req_pc"}, bus.req_pc, v.ereq);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        bus.instr_ready    = 1'b0;
        bus.req_accept     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h100));
`ifdef FETCH_NEXT_LINE_PREFETCH_EN
        for (int a = 32'h100; a <= 32'h14C; a += 4)
            vecs.push_back(mk(1, 1, 0, 0, 1, 32'(a), (a == 32'h100), 1, 32'h140));
`else
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h100, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h104, 1, 0, 0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 0, 0, 0, 1, 32'h108, 1, 0, 0));
        for (int a = 32'h108; a <= 32'h13C; a += 4)
            vecs.push_back(mk(1, 0, 0, 0, 1, 32'(a), 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h140));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h140, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h2034, 1, 32'h144, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h2000));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h2000));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h2034, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h2038, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h203C, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h400, 0, 0, 1, 1, 32'h2040));
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h2040));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h2040));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h400));
        vecs.push_back(mk(1, 0, 1, 32'hFFFF_FFFB, 1, 32'h400, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'hFFFF_FFC0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'hFFFF_FFF8, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 0));
        vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 32'h0, 1, 0, 0));
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset.instr_valid", 32'(bus.instr_valid), 32'd0);
        check("reset.req_rd", 32'(bus.req_rd), 32'd0);
        check("reset.req_pc", bus.req_pc, 32'h100);
        check("reset.instr_pc", bus.instr_pc, RESET_PC);
        check("reset.instr_data", bus.instr_data, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i], $sformatf("vec%0d", i));

`ifndef FETCH_NEXT_LINE_PREFETCH_EN
        // Redirect landing on the accept cycle, then redirects stacked inside DRAIN.
        step(mk(0, 0, 1, 32'h500, 1, 32'h4, 1, 0, 0), "redir_stream");
        step(mk(1, 1, 1, 32'h600, 0, 0, 1, 1, 32'h500), "redir_on_accept");
        step(mk(1, 0, 0, 0, 0, 0, 1, 1, 32'h600), "discarded_line");
        step(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h600), "req_600");
        step(mk(0, 0, 1, 32'h700, 1, 32'h600, 1, 0, 0), "stream_600");
        step(mk(1, 0, 1, 32'h800, 0, 0, 1, 1, 32'h700), "redir_pending");
        step(mk(1, 0, 1, 32'h900, 0, 0, 1, 1, 32'h700), "redir_in_drain");
        step(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h700), "drain_accept");
        step(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h900), "req_900");
        step(mk(1, 0, 0, 0, 1, 32'h900, 1, 0, 0), "stream_900");
`endif

        // Reset wins over a simultaneous redirect and accept.
        rst                = 1'b1;
        bus.instr_ready    = 1'b1;
        bus.req_accept     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h3000;
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_override.instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_override.req_rd", 32'(bus.req_rd), 32'd0);
        check("rst_override.instr_pc", bus.instr_pc, RESET_PC);
        check("rst_override.instr_data", bus.instr_data, 32'h0);
        rst = 1'b0;
        step(mk(1, 0, 0, 0, 0, 0, 1, 0, 0), "post_rst_idle");
        step(mk(1, 1, 0, 0, 0, 0, 1, 1, 32'h100), "post_rst_req");
        step(mk(1, 0, 0, 0, 1, 32'h100, 0, 0, 0), "post_rst_stream");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
